// File: rtl/psum_accumulator.sv
// Partial-sum accumulator for one row of systolic PE outputs: sums a programmed
// number of product beats per lane with signed saturation, then holds the result for write-back.
module psum_accumulator #(
  parameter int NUM_COLS = 4,
  parameter int ACC_W    = 20,
  parameter int LEN_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [LEN_W-1:0]          len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_COLS*16-1:0]    in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_COLS*ACC_W-1:0] out_data,
  output logic                      busy,
  output logic [NUM_COLS-1:0]       sat
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q [NUM_COLS];
  logic [ACC_W-1:0]    acc_d [NUM_COLS];
  logic [NUM_COLS-1:0] sat_q, sat_d;

  logic [ACC_W:0]      lane_sum  [NUM_COLS];
  logic [ACC_W-1:0]    lane_next [NUM_COLS];
  logic [NUM_COLS-1:0] lane_ovf;

  // Per-lane add one bit wider than the accumulator; the top two bits
  // disagreeing means the true sum left the representable range.
  always_comb begin
    for (int i = 0; i < NUM_COLS; i++) begin
      lane_sum[i] = {acc_q[i][ACC_W-1], acc_q[i]}
                  + {{(ACC_W-15){in_data[16*i+15]}}, in_data[16*i +: 16]};
      lane_ovf[i] = lane_sum[i][ACC_W] ^ lane_sum[i][ACC_W-1];
      if (lane_ovf[i]) begin
        lane_next[i] = lane_sum[i][ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
        lane_next[i] = lane_sum[i][ACC_W-1:0];
      end
    end
  end

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          state_d = ACCUM;
          cnt_d   = len;
          sat_d   = '0;
          for (int i = 0; i < NUM_COLS; i++) acc_d[i] = '0;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          cnt_d = cnt_q - LEN_W'(1);
          sat_d = sat_q | lane_ovf;
          for (int i = 0; i < NUM_COLS; i++) acc_d[i] = lane_next[i];
          if (cnt_q == LEN_W'(1)) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sat_q   <= '0;
      // NOTE: the accumulator array is a handful of flops, not RAM, and a
      // reset mid-job must leave zeros visible, so it is reset explicitly.
      for (int i = 0; i < NUM_COLS; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      for (int i = 0; i < NUM_COLS; i++) acc_q[i] <= acc_d[i];
    end
  end

  // Handshake flags come straight from the state register.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign sat       = sat_q;

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_COLS; i++) out_data[ACC_W*i +: ACC_W] = acc_q[i];
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomised and directed bench for psum_accumulator: a task-level driver pushes
// expected sums from a plain-integer model; a negedge monitor pops and compares.
module tb_psum_accumulator;

  localparam int NUM_COLS = 4;
  localparam int ACC_W    = 20;
  localparam int LEN_W    = 8;
  localparam int ACC_MAX  = (1 << (ACC_W-1)) - 1;
  localparam int ACC_MIN  = -(1 << (ACC_W-1));

  typedef struct packed {
    logic [NUM_COLS*ACC_W-1:0] data;
    logic [NUM_COLS-1:0]       sat;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      start;
  logic [LEN_W-1:0]          len;
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_COLS*16-1:0]    in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_COLS*ACC_W-1:0] out_data;
  logic                      busy;
  logic [NUM_COLS-1:0]       sat;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [15:0] prod [256][NUM_COLS];

  psum_accumulator #(.NUM_COLS(NUM_COLS), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_lane(input string name, input int l, input int expv);
    logic [ACC_W-1:0] a;
    logic [ACC_W-1:0] e;
    a = out_data[ACC_W*l +: ACC_W];
    e = ACC_W'(expv);
    check(name, 128'(a), 128'(e));
  endtask

  // Reference: straightforward integer accumulation with clamping.
  function automatic exp_t model(input int n);
    exp_t r;
    int   acc [NUM_COLS];
    r = '0;
    for (int l = 0; l < NUM_COLS; l++) acc[l] = 0;
    for (int b = 0; b < n; b++) begin
      for (int l = 0; l < NUM_COLS; l++) begin
        acc[l] = acc[l] + int'($signed(prod[b][l]));
        if (acc[l] > ACC_MAX) begin
          acc[l] = ACC_MAX;
          r.sat[l] = 1'b1;
        end else if (acc[l] < ACC_MIN) begin
          acc[l] = ACC_MIN;
          r.sat[l] = 1'b1;
        end
      end
    end
    for (int l = 0; l < NUM_COLS; l++) r.data[ACC_W*l +: ACC_W] = ACC_W'(acc[l]);
    return r;
  endfunction

  task automatic fill_random(input int n, input int span);
    for (int b = 0; b < n; b++)
      for (int l = 0; l < NUM_COLS; l++)
        prod[b][l] = 16'($urandom_range(2*span, 0) - span);
  endtask

  task automatic do_start(input int n);
    start    = 1'b1;
    len      = LEN_W'(n);
    in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    len   = LEN_W'($urandom);
  endtask

  // Gap cycles carry junk data with in_valid low plus stray start pulses.
  task automatic send_beat(input int b, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
      start    = 1'($urandom_range(1, 0));
      len      = LEN_W'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int l = 0; l < NUM_COLS; l++) in_data[16*l +: 16] = prod[b][l];
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
  endtask

  task automatic run_job(input int n, input int gap_min, input int gap_max, input int low);
    exp_q.push_back(model(n));
    out_ready = (low == 0);
    do_start(n);
    check("start_to_accum", {126'b0, busy, in_ready}, 128'b11);
    for (int b = 0; b < n; b++) send_beat(b, $urandom_range(gap_max, gap_min));
    check("last_beat_latency", {126'b0, out_valid, in_ready}, 128'b10);
  endtask

  // In HOLD with out_ready low, drive beats and starts that must be ignored.
  task automatic finish_job(input int low);
    for (int c = 0; c < low; c++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(1, 0));
      in_data   = {$urandom, $urandom};
      start     = 1'($urandom_range(1, 0));
      len       = LEN_W'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_after_handshake", {126'b0, busy, out_valid}, 128'b0);
  endtask

  // Monitor: scoreboard pop on handshake, stability and in_ready checks in HOLD.
  logic                      prev_hold = 1'b0;
  logic [NUM_COLS*ACC_W-1:0] held_data;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else if (out_valid) begin
      check("hold_in_ready_low", {127'b0, in_ready}, 128'b0);
      if (prev_hold) check("hold_data_stable", 128'(out_data), 128'(held_data));
      held_data = out_data;
      prev_hold = !out_ready;
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %0h expected none", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result_data", 128'(out_data), 128'(e.data));
          check("result_sat", 128'(sat), 128'(e.sat));
        end
      end
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #12;
    check("reset_busy",      {127'b0, busy},      128'b0);
    check("reset_in_ready",  {127'b0, in_ready},  128'b0);
    check("reset_out_valid", {127'b0, out_valid}, 128'b0);
    check("reset_out_data",  128'(out_data),      128'b0);
    check("reset_sat",       128'(sat),           128'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a job.
    fill_random(4, 20000);
    do_start(4);
    check("midreset_started", {127'b0, in_ready}, 128'b1);
    send_beat(0, 0);
    send_beat(1, 0);
    reset_n = 1'b0;
    #1;
    check("midreset_busy",      {127'b0, busy},      128'b0);
    check("midreset_out_valid", {127'b0, out_valid}, 128'b0);
    check("midreset_out_data",  128'(out_data),      128'b0);
    check("midreset_sat",       128'(sat),           128'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic sum with known lane totals.
    prod[0][0] = 16'd100;   prod[0][1] = -16'sd50; prod[0][2] = 16'd7;  prod[0][3] = 16'd0;
    prod[1][0] = -16'sd1;   prod[1][1] = -16'sd1;  prod[1][2] = -16'sd1; prod[1][3] = 16'd0;
    prod[2][0] = 16'd32767; prod[2][1] = 16'd0;    prod[2][2] = 16'd0;  prod[2][3] = 16'd0;
    run_job(3, 0, 0, 2);
    check_lane("basic_lane0", 0, 32866);
    check_lane("basic_lane1", 1, -51);
    check_lane("basic_lane2", 2, 6);
    check_lane("basic_lane3", 3, 0);
    check("basic_sat", 128'(sat), 128'b0);
    finish_job(2);

    // Gapped beats and five cycles of backpressure.
    fill_random(2, 30000);
    run_job(2, 3, 3, 5);
    finish_job(5);

    // Positive saturation on lane 0.
    fill_random(33, 100);
    for (int b = 0; b < 33; b++) begin
      prod[b][0] = 16'd16384;
      prod[b][1] = 16'd0;
    end
    run_job(33, 0, 1, 1);
    check_lane("pos_sat_lane0", 0, 524287);
    check_lane("pos_sat_lane1", 1, 0);
    check("pos_sat_flags", 128'(sat[1:0]), 128'b01);
    finish_job(1);

    // Negative saturation on lane 1.
    fill_random(17, 100);
    for (int b = 0; b < 17; b++) begin
      prod[b][0] = 16'd0;
      prod[b][1] = 16'h8000;
    end
    run_job(17, 0, 1, 1);
    check_lane("neg_sat_lane1", 1, -524288);
    check_lane("neg_sat_lane0", 0, 0);
    check("neg_sat_flags", 128'(sat[1:0]), 128'b10);
    finish_job(1);

    // start with len = 0 is ignored.
    do_start(0);
    check("zero_len_start", {126'b0, busy, in_ready}, 128'b0);

    // Back-to-back len = 1 jobs with out_ready tied high.
    fill_random(1, 32768);
    run_job(1, 0, 0, 0);
    finish_job(0);
    fill_random(1, 32768);
    run_job(1, 0, 0, 0);
    finish_job(0);

    // Randomised jobs, full-range products so saturation occurs sometimes.
    for (int j = 0; j < 24; j++) begin
      int n;
      int low;
      n   = $urandom_range(20, 1);
      low = $urandom_range(3, 0);
      fill_random(n, 32768);
      run_job(n, 0, 2, low);
      finish_job(low);
    end

    @(posedge clk); #1;
    check("scoreboard_drained", 128'(exp_q.size()), 128'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
